// File: rtl/pipe_gap_pkg.sv
// -----------------------------------------------------------------------------
// pipe_gap_pkg
//   Shared definitions for the pipe gap generator:
//     - state_t     : run-control FSM encoding (IDLE / RUN / DONE)
//     - LFSR_TAPS   : Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
//     - draw_byte   : per-channel byte selection from the LFSR
//     - draw_gap    : byte -> quantised gap height, no divider
//     - slew_clamp  : limits the change between consecutive gaps (used only
//                     when PIPE_GAP_SLEW_EN is defined)
// -----------------------------------------------------------------------------
package pipe_gap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Right-shifting Galois LFSR: bits 15,13,12,10 receive the feedback.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Channel k reads 8 bits starting at bit 3k, wrapping around bit 15.
    // Doubling the word makes the wrap a plain shift.
    function automatic logic [7:0] draw_byte(input logic [15:0] lfsr, input int unsigned k);
        logic [31:0] dbl;
        dbl = {lfsr, lfsr} >> ((3 * k) % 16);
        return dbl[7:0];
    endfunction

    // idx = (b * num_steps) >> 8 maps 0..255 evenly onto 0..num_steps-1.
    function automatic int draw_gap(input logic [15:0] lfsr, input int unsigned k,
                                    input int min_gap, input int step, input int num_steps);
        logic [7:0]  b;
        logic [15:0] prod;
        logic [7:0]  idx;
        b    = draw_byte(lfsr, k);
        prod = 16'(b) * 16'(num_steps);
        idx  = prod[15:8];
        return min_gap + step * int'(idx);
    endfunction

    // Clamp first to old +/- max_delta, then to the legal gap range.
    function automatic int slew_clamp(input int draw, input int old, input int max_delta,
                                      input int lo, input int hi);
        int v;
        v = draw;
        if (v > old + max_delta) v = old + max_delta;
        if (v < old - max_delta) v = old - max_delta;
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        return v;
    endfunction

endpackage

// File: rtl/gap_lfsr.sv
// -----------------------------------------------------------------------------
// gap_lfsr
//   16-bit Galois LFSR (x^16 + x^14 + x^13 + x^11 + 1) that advances every
//   clock. A Load pulse replaces the step with Value ^ LoadXor, falling back
//   to SEED when that result is zero so the register never locks up.
// Ports:
//   Clk      in   system clock
//   Reset    in   synchronous active-low reset (Value <= SEED)
//   Load     in   reseed strobe
//   LoadXor  in   value mixed into the state on Load
//   Value    out  current LFSR state
// -----------------------------------------------------------------------------
module gap_lfsr
    import pipe_gap_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Load,
    input  logic [15:0] LoadXor,
    output logic [15:0] Value
);

    logic [15:0] step_val;
    logic [15:0] mix_val;
    logic [15:0] value_d;

    always_comb begin
        step_val = Value[0] ? ((Value >> 1) ^ LFSR_TAPS) : (Value >> 1);
        mix_val  = Value ^ LoadXor;
        value_d  = step_val;
        if (Load) begin
            value_d = (mix_val == 16'd0) ? SEED : mix_val;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            Value <= SEED;
        end else begin
            Value <= value_d;
        end
    end

endmodule

// File: rtl/pipe_gap_generator.sv
// -----------------------------------------------------------------------------
// pipe_gap_generator
//   Produces a fresh gap height for each pipe channel every time that pipe
//   wraps to x=0, using an LFSR rather than fixed tables. A run starts on a
//   flap press, lasts LEVELS pipes per channel, then parks every gap at
//   END_GAP (off-screen) and reports Done.
//
//   Optional build macro: PIPE_GAP_SLEW_EN -- when defined, each drawn gap
//   is clamped to within MAX_DELTA of that channel's previous gap (start load
//   and END_GAP are not clamped). Undefined: raw draws are used.
//
// Ports:
//   Clk       in   system clock
//   Reset     in   synchronous active-low reset, wins over everything
//   Tick      in   game-rate strobe; qualifies Button and PipePos
//   Button    in   flap button, active-low; starts/restarts a run
//   PipePos   in   x-position of pipe k at [k*GAP_W +: GAP_W]
//   Gap       out  gap height of pipe k at [k*GAP_W +: GAP_W]
//   Running   out  high while a run is in progress
//   Done      out  high once every channel has finished
//   Level     out  channel 0 pipe count (score)
//   DbgState  out  current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: there is no valid/ready traffic here; Tick is a one-cycle
// qualifier and every input is only acted on in a cycle where Tick is high.
// -----------------------------------------------------------------------------
module pipe_gap_generator
    import pipe_gap_pkg::*;
#(
    parameter int          NUM_PIPES = 2,
    parameter int          GAP_W     = 16,
    parameter int          LEVELS    = 50,
    parameter int          MIN_GAP   = 40,
    parameter int          STEP      = 20,
    parameter int          NUM_STEPS = 7,
    parameter int          END_GAP   = 395,
    parameter int          MAX_DELTA = 60,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Tick,
    input  logic                       Button,
    input  logic [NUM_PIPES*GAP_W-1:0] PipePos,
    output logic [NUM_PIPES*GAP_W-1:0] Gap,
    output logic                       Running,
    output logic                       Done,
    output logic [7:0]                 Level,
    output logic [1:0]                 DbgState
);

    localparam int CNT_W   = 8;
    localparam int MID_GAP = MIN_GAP + STEP * (NUM_STEPS / 2);
    localparam int HI_GAP  = MIN_GAP + STEP * (NUM_STEPS - 1);

    state_t               state_q;
    state_t               state_d;
    logic                 start;
    logic                 press;
    logic [15:0]          free_cnt;
    logic [15:0]          lfsr;
    logic [NUM_PIPES-1:0] finished;
    logic [CNT_W-1:0]     count_arr [NUM_PIPES];

    // ------------------------------------------------------------------
    // Run-control FSM
    // ------------------------------------------------------------------
    assign press = Tick && !Button;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Button only matters outside RUN; a press there is the start event.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (press) begin
                    start   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (&finished) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (press) begin
                    start   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign Running  = (state_q == ST_RUN);
    assign Done     = (state_q == ST_DONE);
    assign DbgState = state_q;

    // ------------------------------------------------------------------
    // Entropy: free-running counter is folded into the LFSR at each start
    // so the gap sequence depends on how long the player waited.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            free_cnt <= 16'd0;
        end else begin
            free_cnt <= free_cnt + 16'd1;
        end
    end

    gap_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .Clk     (Clk),
        .Reset   (Reset),
        .Load    (start),
        .LoadXor (free_cnt),
        .Value   (lfsr)
    );

    // ------------------------------------------------------------------
    // Per-channel gap logic. Each channel reads a different byte of the
    // same LFSR state, so simultaneous arrivals get independent draws.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_PIPES; k++) begin : g_chan
        logic [GAP_W-1:0] pos;
        logic [GAP_W-1:0] gap_q;
        logic [GAP_W-1:0] raw_draw;
        logic [GAP_W-1:0] arr_draw;
        logic [CNT_W-1:0] cnt_q;
        logic             prev_zero_q;
        logic             fin_q;
        logic             at_zero;
        logic             arrival;

        assign pos      = PipePos[k*GAP_W +: GAP_W];
        assign at_zero  = (pos == '0);
        // Edge-detect on x==0 so a pipe resting at 0 counts once per wrap.
        assign arrival  = Tick && (state_q == ST_RUN) && at_zero && !prev_zero_q && !fin_q;
        assign raw_draw = GAP_W'(draw_gap(lfsr, k, MIN_GAP, STEP, NUM_STEPS));

`ifdef PIPE_GAP_SLEW_EN
        assign arr_draw = GAP_W'(slew_clamp(int'(raw_draw), int'(gap_q), MAX_DELTA,
                                            MIN_GAP, HI_GAP));
`else
        assign arr_draw = raw_draw;
`endif

        always_ff @(posedge Clk) begin
            if (!Reset) begin
                gap_q       <= GAP_W'(MID_GAP);
                cnt_q       <= '0;
                prev_zero_q <= 1'b1;
                fin_q       <= 1'b0;
            end else begin
                if (Tick) begin
                    prev_zero_q <= at_zero;
                end
                if (start) begin
                    // Start load is the first pipe of the run; never clamped.
                    gap_q <= raw_draw;
                    cnt_q <= CNT_W'(1);
                    fin_q <= 1'b0;
                end else if (arrival) begin
                    if (cnt_q < CNT_W'(LEVELS)) begin
                        gap_q <= arr_draw;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        gap_q <= GAP_W'(END_GAP);
                        fin_q <= 1'b1;
                    end
                end
            end
        end

        assign Gap[k*GAP_W +: GAP_W] = gap_q;
        assign finished[k]           = fin_q;
        assign count_arr[k]          = cnt_q;
    end

    // Score display follows channel 0 and never shows more than LEVELS.
    assign Level = (count_arr[0] > CNT_W'(LEVELS)) ? CNT_W'(LEVELS) : count_arr[0];

endmodule

// File: tb/tb_pipe_gap_generator.sv
// -----------------------------------------------------------------------------
// tb_pipe_gap_generator
//   Self-checking bench for pipe_gap_generator (two channels). A behavioural
//   model tracks the game rules cycle by cycle from the same inputs; each
//   scenario task compares DUT outputs against it and against fixed values.
//   Define PIPE_GAP_SLEW_EN on both bench and RTL to exercise the slew clamp.
// -----------------------------------------------------------------------------
module tb_pipe_gap_generator;

    localparam int          NP        = 2;
    localparam int          GW        = 16;
    localparam int          LEVELS    = 50;
    localparam int          MIN_GAP   = 40;
    localparam int          STEP      = 20;
    localparam int          NUM_STEPS = 7;
    localparam int          END_GAP   = 395;
    localparam int          MAX_DELTA = 60;
    localparam int          MID_GAP   = 100;
    localparam logic [15:0] SEED      = 16'hACE1;

    // ---------------- clock / reset / DUT ----------------
    logic           Clk    = 1'b0;
    logic           Reset  = 1'b0;
    logic           Tick   = 1'b0;
    logic           Button = 1'b1;
    logic [GW-1:0]  pos [NP];
    logic [NP*GW-1:0] PipePos;
    logic [NP*GW-1:0] Gap;
    logic           Running;
    logic           Done;
    logic [7:0]     Level;
    logic [1:0]     DbgState;
    logic [GW-1:0]  gap0;
    logic [GW-1:0]  gap1;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    assign PipePos = {pos[1], pos[0]};
    assign gap0    = Gap[GW-1:0];
    assign gap1    = Gap[2*GW-1:GW];

    pipe_gap_generator #(
        .NUM_PIPES (NP),
        .GAP_W     (GW),
        .LEVELS    (LEVELS),
        .MIN_GAP   (MIN_GAP),
        .STEP      (STEP),
        .NUM_STEPS (NUM_STEPS),
        .END_GAP   (END_GAP),
        .MAX_DELTA (MAX_DELTA),
        .SEED      (SEED)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Tick     (Tick),
        .Button   (Button),
        .PipePos  (PipePos),
        .Gap      (Gap),
        .Running  (Running),
        .Done     (Done),
        .Level    (Level),
        .DbgState (DbgState)
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int ref_draw(input logic [15:0] s, input int k);
        logic [31:0] d;
        int b;
        d = {s, s};
        b = int'((d >> ((3 * k) % 16)) & 32'hFF);
        return MIN_GAP + STEP * ((b * NUM_STEPS) / 256);
    endfunction

    function automatic int ref_slew(input int d, input int old);
        int v;
        v = d;
`ifdef PIPE_GAP_SLEW_EN
        if (v > old + MAX_DELTA) v = old + MAX_DELTA;
        if (v < old - MAX_DELTA) v = old - MAX_DELTA;
        if (v < MIN_GAP) v = MIN_GAP;
        if (v > MIN_GAP + STEP * (NUM_STEPS - 1)) v = MIN_GAP + STEP * (NUM_STEPS - 1);
`else
        if (old < 0) v = 0;
`endif
        return v;
    endfunction

    int          m_state;   // 0 idle, 1 run, 2 done
    int          m_gap [NP];
    int          m_cnt [NP];
    logic [NP-1:0] m_prev;
    logic [NP-1:0] m_fin;
    logic [15:0] m_lfsr;
    logic [15:0] m_free;

    always @(posedge Clk) begin
        if (!Reset) begin
            m_state <= 0;
            m_lfsr  <= SEED;
            m_free  <= 16'd0;
            m_prev  <= '1;
            m_fin   <= '0;
            for (int k = 0; k < NP; k++) begin
                m_gap[k] <= MID_GAP;
                m_cnt[k] <= 0;
            end
        end else begin
            m_free <= m_free + 16'd1;
            if (m_state != 1 && Tick && !Button) begin
                m_state <= 1;
                m_lfsr  <= ((m_lfsr ^ m_free) == 16'd0) ? SEED : (m_lfsr ^ m_free);
                m_fin   <= '0;
                for (int k = 0; k < NP; k++) begin
                    m_gap[k] <= ref_draw(m_lfsr, k);
                    m_cnt[k] <= 1;
                end
            end else begin
                m_lfsr <= lfsr_next(m_lfsr);
                if (m_state == 1 && (&m_fin)) m_state <= 2;
                for (int k = 0; k < NP; k++) begin
                    if (m_state == 1 && Tick && pos[k] == '0 && !m_prev[k] && !m_fin[k]) begin
                        if (m_cnt[k] < LEVELS) begin
                            m_gap[k] <= ref_slew(ref_draw(m_lfsr, k), m_gap[k]);
                            m_cnt[k] <= m_cnt[k] + 1;
                        end else begin
                            m_gap[k] <= END_GAP;
                            m_fin[k] <= 1'b1;
                        end
                    end
                end
            end
            for (int k = 0; k < NP; k++) begin
                if (Tick) m_prev[k] <= (pos[k] == '0);
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset = 1'b0; Tick = 1'b0; Button = 1'b1; pos[0] = 16'd7; pos[1] = 16'd13;
        repeat (3) @(negedge Clk);
        checks++; if (gap0 !== 16'd100) begin errors++; $display("FAIL reset_gap0: got %0d expected 100", gap0); end
        checks++; if (gap1 !== 16'd100) begin errors++; $display("FAIL reset_gap1: got %0d expected 100", gap1); end
        checks++; if (Running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b expected 0", Running); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", Done); end
        checks++; if (Level !== 8'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", Level); end
        checks++; if (DbgState !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", DbgState); end
        Reset = 1'b1; Tick = 1'b1;
        repeat (1000) @(negedge Clk);
        checks++; if (gap0 !== 16'd100 || gap1 !== 16'd100) begin errors++; $display("FAIL idle_gaps: got %0d,%0d expected 100,100", gap0, gap1); end
        checks++; if (Running !== 1'b0 || Level !== 8'd0) begin errors++; $display("FAIL idle_run_level: got %0b/%0d expected 0/0", Running, Level); end
    endtask

    task automatic test_start();
        Tick = 1'b1; Button = 1'b0;
        @(negedge Clk);
        Button = 1'b1;
        checks++; if (Running !== 1'b1) begin errors++; $display("FAIL start_running: got %0b expected 1", Running); end
        checks++; if (Level !== 8'd1) begin errors++; $display("FAIL start_level: got %0d expected 1", Level); end
        checks++; if (gap0 < 40 || gap0 > 160 || (gap0 - 40) % 20 != 0) begin errors++; $display("FAIL start_gap0_legal: got %0d expected one of 40..160 step 20", gap0); end
        checks++; if (gap1 < 40 || gap1 > 160 || (gap1 - 40) % 20 != 0) begin errors++; $display("FAIL start_gap1_legal: got %0d expected one of 40..160 step 20", gap1); end
        checks++; if (int'(gap0) !== m_gap[0]) begin errors++; $display("FAIL start_gap0_model: got %0d expected %0d", gap0, m_gap[0]); end
        checks++; if (int'(gap1) !== m_gap[1]) begin errors++; $display("FAIL start_gap1_model: got %0d expected %0d", gap1, m_gap[1]); end
    endtask

    task automatic test_hold_zero();
        logic [GW-1:0] g1_before;
        logic [7:0]    lvl_prev;
        int            changes;
        g1_before = gap1; lvl_prev = Level; changes = 0;
        pos[0] = 16'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (Level != lvl_prev) changes++;
            lvl_prev = Level;
            checks++; if (int'(gap0) !== m_gap[0]) begin errors++; $display("FAIL hold_gap0_model: got %0d expected %0d", gap0, m_gap[0]); end
        end
        checks++; if (changes != 1) begin errors++; $display("FAIL hold_one_update: got %0d expected 1", changes); end
        checks++; if (Level !== 8'd2) begin errors++; $display("FAIL hold_level: got %0d expected 2", Level); end
        checks++; if (gap1 !== g1_before) begin errors++; $display("FAIL hold_gap1_stable: got %0d expected %0d", gap1, g1_before); end
        pos[0] = 16'd9;
        @(negedge Clk);
    endtask

    task automatic test_simultaneous();
        int exp0;
        int exp1;
        exp0 = ref_slew(ref_draw(m_lfsr, 0), int'(gap0));
        exp1 = ref_slew(ref_draw(m_lfsr, 1), int'(gap1));
        pos[0] = 16'd0; pos[1] = 16'd0;
        @(negedge Clk);
        checks++; if (int'(gap0) !== exp0) begin errors++; $display("FAIL simul_gap0: got %0d expected %0d", gap0, exp0); end
        checks++; if (int'(gap1) !== exp1) begin errors++; $display("FAIL simul_gap1: got %0d expected %0d", gap1, exp1); end
        checks++; if (Level !== 8'd3) begin errors++; $display("FAIL simul_level: got %0d expected 3", Level); end
        checks++; if (m_cnt[1] != 2) begin errors++; $display("FAIL simul_count1: got %0d expected 2", m_cnt[1]); end
        pos[0] = 16'd5; pos[1] = 16'd5;
        @(negedge Clk);
    endtask

    task automatic test_full_run();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            pos[0] = (i % 2 == 0) ? 16'd0 : 16'd5;
            pos[1] = pos[0];
            @(negedge Clk);
            checks++; if (int'(gap0) !== m_gap[0] || int'(gap1) !== m_gap[1]) begin errors++; $display("FAIL run_gaps_model: got %0d,%0d expected %0d,%0d", gap0, gap1, m_gap[0], m_gap[1]); end
            checks++; if (int'(Level) !== m_cnt[0]) begin errors++; $display("FAIL run_level_model: got %0d expected %0d", Level, m_cnt[0]); end
            if (gap0 == 16'(END_GAP) && gap1 == 16'(END_GAP)) begin
                seen = 1'b1;
                checks++; if (Done !== 1'b0) begin errors++; $display("FAIL done_early: got %0b expected 0", Done); end
                @(negedge Clk);
                checks++; if (Done !== 1'b1) begin errors++; $display("FAIL done_set: got %0b expected 1", Done); end
                checks++; if (Running !== 1'b0) begin errors++; $display("FAIL done_running: got %0b expected 0", Running); end
                checks++; if (Level !== 8'd50) begin errors++; $display("FAIL done_level: got %0d expected 50", Level); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL run_end_gap: got not reached expected 395 on both within 400 cycles"); end
        pos[0] = 16'd5; pos[1] = 16'd5;
        Button = 1'b0;
        @(negedge Clk);
        Button = 1'b1;
        checks++; if (Running !== 1'b1 || Done !== 1'b0) begin errors++; $display("FAIL restart_state: got run=%0b done=%0b expected run=1 done=0", Running, Done); end
        checks++; if (Level !== 8'd1) begin errors++; $display("FAIL restart_level: got %0d expected 1", Level); end
        checks++; if (int'(gap0) !== m_gap[0] || int'(gap1) !== m_gap[1]) begin errors++; $display("FAIL restart_gaps: got %0d,%0d expected %0d,%0d", gap0, gap1, m_gap[0], m_gap[1]); end
    endtask

    task automatic test_random();
        logic          pr;
        logic [GW-1:0] pg0;
        logic [GW-1:0] pg1;
        for (int i = 0; i < 12000; i++) begin
            Tick   = ($urandom_range(0, 3) != 0);
            Button = ($urandom_range(0, 60) != 0);
            pos[0] = 16'($urandom_range(0, 2));
            pos[1] = 16'($urandom_range(0, 2));
            pr = Running; pg0 = gap0; pg1 = gap1;
            @(negedge Clk);
            checks++; if (int'(gap0) !== m_gap[0]) begin errors++; $display("FAIL rand_gap0: cycle %0d got %0d expected %0d", i, gap0, m_gap[0]); end
            checks++; if (int'(gap1) !== m_gap[1]) begin errors++; $display("FAIL rand_gap1: cycle %0d got %0d expected %0d", i, gap1, m_gap[1]); end
            checks++; if (Running !== (m_state == 1) || Done !== (m_state == 2)) begin errors++; $display("FAIL rand_state: cycle %0d got run=%0b done=%0b expected state %0d", i, Running, Done, m_state); end
            checks++; if (int'(Level) !== m_cnt[0]) begin errors++; $display("FAIL rand_level: cycle %0d got %0d expected %0d", i, Level, m_cnt[0]); end
`ifdef PIPE_GAP_SLEW_EN
            if (pr && Running && gap0 != 16'(END_GAP) && pg0 != 16'(END_GAP)) begin
                checks++; if ((gap0 > pg0 ? gap0 - pg0 : pg0 - gap0) > 16'(MAX_DELTA)) begin errors++; $display("FAIL slew_gap0: got %0d after %0d expected delta <= 60", gap0, pg0); end
            end
            if (pr && Running && gap1 != 16'(END_GAP) && pg1 != 16'(END_GAP)) begin
                checks++; if ((gap1 > pg1 ? gap1 - pg1 : pg1 - gap1) > 16'(MAX_DELTA)) begin errors++; $display("FAIL slew_gap1: got %0d after %0d expected delta <= 60", gap1, pg1); end
            end
`else
            if (pr && pg0 == pg1 && pg0 == 16'hFFFF) checks = checks;
`endif
        end
        Button = 1'b1;
    endtask

    task automatic test_mid_reset();
        Tick = 1'b1; Button = 1'b0; pos[0] = 16'd5; pos[1] = 16'd5;
        @(negedge Clk);
        Button = 1'b1;
        repeat (3) @(negedge Clk);
        checks++; if (Running !== 1'b1) begin errors++; $display("FAIL midrst_pre_running: got %0b expected 1", Running); end
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        checks++; if (Running !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL midrst_state: got run=%0b done=%0b expected 0/0", Running, Done); end
        checks++; if (gap0 !== 16'd100 || gap1 !== 16'd100) begin errors++; $display("FAIL midrst_gaps: got %0d,%0d expected 100,100", gap0, gap1); end
        checks++; if (Level !== 8'd0) begin errors++; $display("FAIL midrst_level: got %0d expected 0", Level); end
        repeat (5) @(negedge Clk);
        checks++; if (Running !== 1'b0 || DbgState !== 2'd0) begin errors++; $display("FAIL midrst_idle_hold: got run=%0b state=%0d expected 0/0", Running, DbgState); end
    endtask

    initial begin
        pos[0] = 16'd7;
        pos[1] = 16'd13;
        test_reset();
        test_start();
        test_hold_zero();
        test_simultaneous();
        test_full_run();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
